instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of the word-addressed instruction memory. Holds the PC,

---
 rtl/instruction_fetch.sv | 57 +++++
 tb/tb_instruction_fetch.sv | 128 ++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, next-PC select and IF/ID pipeline register with fetch counter
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump_taken,
    input  logic [25:0] jump_index,
    input  logic [31:0] redirect_pc_plus1,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus1,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);
    localparam logic [31:0] PC_MASK = 32'(MEM_DEPTH - 1);
    logic        redirect;
    logic [31:0] pc_plus1;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    always_comb begin
        redirect      = jump_taken | branch_taken;
        pc_plus1      = (pc_out + 32'd1) & PC_MASK;
        branch_target = redirect_pc_plus1 + {{16{branch_offset[15]}}, branch_offset};
        jump_target   = {redirect_pc_plus1[31:26], jump_index};
        next_pc       = (jump_taken ? jump_target : branch_taken ? branch_target : stall ? pc_out : pc_plus1) & PC_MASK;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out        <= RESET_PC & PC_MASK;
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus1 <= 32'd0;
            ifid_valid    <= 1'b0;
            fetch_count   <= 32'd0;
        end else begin
            pc_out <= next_pc;
            if (redirect || flush) begin
                ifid_instr    <= NOP_INSTR;
                ifid_pc_plus1 <= 32'd0;
                ifid_valid    <= 1'b0;
            end else if (!stall) begin
                ifid_instr    <= instr_in;
                ifid_pc_plus1 <= pc_plus1;
                ifid_valid    <= 1'b1;
                fetch_count   <= fetch_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboarded random and directed checks of instruction_fetch against a reference model
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        jump_taken = 1'b0;
    logic [25:0] jump_index = '0;
    logic [31:0] redirect_pc_plus1 = '0;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic [31:0] mem [256];
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp1;
        logic        v;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    longint m_pc = 0;
    logic [31:0] m_instr = 0;
    longint m_pp1 = 0;
    logic m_v = 0;
    longint m_cnt = 0;
    instruction_fetch dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump_taken(jump_taken), .jump_index(jump_index),
        .redirect_pc_plus1(redirect_pc_plus1), .pc_out(pc_out), .instr_in(instr_in),
        .ifid_instr(ifid_instr), .ifid_pc_plus1(ifid_pc_plus1),
        .ifid_valid(ifid_valid), .fetch_count(fetch_count)
    );
    always #5 clk = ~clk;
    assign instr_in = mem[pc_out[7:0]];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("pc_out", pc_out, e.pc);
            check("ifid_instr", ifid_instr, e.instr);
            check("ifid_pc_plus1", ifid_pc_plus1, e.pp1);
            check("ifid_valid", 32'(ifid_valid), 32'(e.v));
            check("fetch_count", fetch_count, e.cnt);
        end
    end
    task automatic step(input logic r, input logic s, input logic f, input logic b,
                        input logic [15:0] off, input logic j, input logic [25:0] idx,
                        input logic [31:0] rp);
        exp_t e;
        longint target;
        @(negedge clk);
        reset = r; stall = s; flush = f; branch_taken = b; branch_offset = off;
        jump_taken = j; jump_index = idx; redirect_pc_plus1 = rp;
        if (r) begin
            m_pc = 0; m_instr = 0; m_pp1 = 0; m_v = 0; m_cnt = 0;
        end else begin
            logic [31:0] cur_instr;
            longint cur_pc;
            cur_instr = mem[m_pc];
            cur_pc = m_pc;
            if (j) target = longint'(rp[31:26]) * 64'd67108864 + longint'(idx);
            else target = (longint'(rp) + longint'($signed(off))) % 64'd4294967296;
            if (target < 0) target += 64'd4294967296;
            m_pc = (j || b) ? target % 256 : s ? m_pc : (m_pc + 1) % 256;
            if (j || b || f) begin
                m_instr = 0; m_pp1 = 0; m_v = 0;
            end else if (!s) begin
                m_instr = cur_instr; m_pp1 = (cur_pc + 1) % 256; m_v = 1;
                m_cnt = (m_cnt + 1) % 64'd4294967296;
            end
        end
        e.pc = 32'(m_pc); e.instr = m_instr; e.pp1 = 32'(m_pp1); e.v = m_v; e.cnt = 32'(m_cnt);
        q.push_back(e);
    endtask
    task automatic nrm(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        foreach (mem[i]) mem[i] = $urandom;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        nrm(5);
        repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0);
        nrm(1);
        step(0, 0, 0, 1, 16'hFFFC, 0, 0, 32'd10);
        nrm(1);
        step(0, 0, 0, 1, 16'h0003, 1, 26'd15, 32'd0);
        step(0, 1, 0, 1, 16'h0002, 0, 0, 32'd40);
        step(0, 1, 0, 0, 0, 1, 26'd90, 32'hFC00_0000);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 26'd255, 32'd0);
        nrm(2);
        step(0, 0, 0, 1, 16'h0000, 0, 0, 32'd300);
        nrm(1);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 16'h0005, 1, 26'd9, 32'd77);
        nrm(2);
        repeat (600) begin
            step(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                 ($urandom % 8) == 0, 16'($urandom), ($urandom % 16) == 0,
                 26'($urandom), $urandom);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
